// File: rtl/acc_bf16_pkg.sv
// Shared BF16 constants and rounding-mode encoding for the accumulator-to-BF16 converter.
package acc_bf16_pkg;

  localparam int BF16_W       = 16;
  localparam int BF16_EXP_W   = 8;
  localparam int BF16_MANT_W  = 7;
  localparam int BF16_BIAS    = 127;
  localparam int BF16_EXP_MAX = 255;

  // Signed exponent working width: covers p - FRAC_BITS + bias (+1 carry) over the whole
  // parameter range, with headroom for a larger bias on lane-level overflow checks.
  localparam int EXP_CALC_W = 12;

  localparam logic [BF16_W-1:0] BF16_POS_INF = 16'h7F80;
  localparam logic [BF16_W-1:0] BF16_NEG_INF = 16'hFF80;

  typedef enum logic {
    RM_RNE   = 1'b0,
    RM_TRUNC = 1'b1
  } round_mode_e;

endpackage

// File: rtl/acc_bf16_lane.sv
// One conversion lane: S1 logic (sign/abs/leading-zero count) and S2 logic
// (normalise, round, pack, exception bits). Purely combinational; the top registers between.
module acc_bf16_lane
  import acc_bf16_pkg::*;
#(
  parameter int ACC_W     = 18,
  parameter int FRAC_BITS = 8,
  parameter int EXP_BIAS  = BF16_BIAS,
  localparam int LZW      = $clog2(ACC_W + 1)
) (
  input  logic [ACC_W-1:0]  acc,
  output logic              s1_sign,
  output logic [ACC_W-1:0]  s1_mag,
  output logic [LZW-1:0]    s1_lzc,
  input  logic              s2_sign,
  input  logic [ACC_W-1:0]  s2_mag,
  input  logic [LZW-1:0]    s2_lzc,
  input  logic              s2_rm,
  output logic [BF16_W-1:0] bf16,
  output logic              ovf,
  output logic              unf,
  output logic              inexact
);

  // Exponent of a value whose MSB sits at the top bit of the accumulator.
  localparam int E_OFS = ACC_W - 1 - FRAC_BITS + EXP_BIAS;

  logic [ACC_W-1:0]      norm;
  logic [ACC_W+7:0]      ext;
  logic                  nz;
  logic [6:0]            mant;
  logic                  g_bit;
  logic                  s_bit;
  logic                  inc;
  logic [7:0]            mant_r;
  logic [EXP_CALC_W-1:0] e_pre;
  logic [EXP_CALC_W-1:0] e_post;
  logic                  e_neg;

  // S1: magnitude in ACC_W unsigned bits (most negative input stays exact), then MSB search.
  always_comb begin
    s1_sign = acc[ACC_W-1];
    s1_mag  = s1_sign ? (~acc + ACC_W'(1)) : acc;
    s1_lzc  = LZW'(ACC_W);
    for (int i = 0; i < ACC_W; i++) begin
      if (s1_mag[i]) s1_lzc = LZW'(ACC_W - 1 - i);
    end
  end

  // S2: left-justify, take 7 mantissa bits plus guard/sticky, round, then clamp to inf/zero.
  always_comb begin
    norm   = s2_mag << s2_lzc;
    ext    = {norm, 8'h00};           // zero-extends short magnitudes below the mantissa
    nz     = ext[ACC_W+7];            // hidden one present <=> nonzero input
    mant   = ext[ACC_W+6 -: 7];
    g_bit  = ext[ACC_W-1];
    s_bit  = |ext[ACC_W-2:0];
    inc    = (s2_rm == RM_RNE) && g_bit && (s_bit || mant[0]);
    mant_r = {1'b0, mant} + {7'b0, inc};
    e_pre  = EXP_CALC_W'(E_OFS) - EXP_CALC_W'(s2_lzc);
    e_post = e_pre + EXP_CALC_W'(mant_r[7]);   // mantissa carry-out bumps the exponent
    e_neg  = e_post[EXP_CALC_W-1];

    bf16    = {s2_sign, e_post[7:0], mant_r[6:0]};
    ovf     = 1'b0;
    unf     = 1'b0;
    inexact = g_bit | s_bit;

    if (!nz) begin
      bf16    = '0;
      inexact = 1'b0;
    end else if (!e_neg && (e_post >= EXP_CALC_W'(BF16_EXP_MAX))) begin
      bf16    = s2_sign ? BF16_NEG_INF : BF16_POS_INF;
      ovf     = 1'b1;
      inexact = 1'b1;
    end else if (e_neg || (e_post == '0)) begin
      bf16    = {s2_sign, 15'b0};
      unf     = 1'b1;
      inexact = 1'b1;
    end
  end

endmodule

// File: rtl/acc_to_bf16_pipe.sv
// Multi-lane two-stage accumulator-to-BF16 converter with valid/ready backpressure
// and sticky exception flags.
module acc_to_bf16_pipe
  import acc_bf16_pkg::*;
#(
  parameter int ACC_W     = 18,
  parameter int FRAC_BITS = 8,
  parameter int LANES     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*ACC_W-1:0]   in_acc,
  input  logic                     round_mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*BF16_W-1:0]  out_bf16,
  input  logic                     clr_flags,
  output logic                     flag_ovf,
  output logic                     flag_unf,
  output logic                     flag_inexact
);

  localparam int LZW = $clog2(ACC_W + 1);

  logic                    s1_valid_reg;
  logic                    s1_rm_reg;
  logic [LANES-1:0]        s1_sign_reg;
  logic [LANES*ACC_W-1:0]  s1_mag_reg;
  logic [LANES*LZW-1:0]    s1_lzc_reg;
  logic [LANES-1:0]        s2_ovf_reg;
  logic [LANES-1:0]        s2_unf_reg;
  logic [LANES-1:0]        s2_inx_reg;

  logic [LANES-1:0]        c1_sign;
  logic [LANES*ACC_W-1:0]  c1_mag;
  logic [LANES*LZW-1:0]    c1_lzc;
  logic [LANES*BF16_W-1:0] c2_bf16;
  logic [LANES-1:0]        c2_ovf;
  logic [LANES-1:0]        c2_unf;
  logic [LANES-1:0]        c2_inx;

  logic s2_en;
  logic xfer;

  // S2 may load when empty or draining; S1 may load when empty or moving into S2.
  assign s2_en    = !out_valid || out_ready;
  assign in_ready = !s1_valid_reg || s2_en;
  assign xfer     = out_valid && out_ready;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    acc_bf16_lane #(
      .ACC_W     (ACC_W),
      .FRAC_BITS (FRAC_BITS)
    ) u_lane (
      .acc     (in_acc[gi*ACC_W +: ACC_W]),
      .s1_sign (c1_sign[gi]),
      .s1_mag  (c1_mag[gi*ACC_W +: ACC_W]),
      .s1_lzc  (c1_lzc[gi*LZW +: LZW]),
      .s2_sign (s1_sign_reg[gi]),
      .s2_mag  (s1_mag_reg[gi*ACC_W +: ACC_W]),
      .s2_lzc  (s1_lzc_reg[gi*LZW +: LZW]),
      .s2_rm   (s1_rm_reg),
      .bf16    (c2_bf16[gi*BF16_W +: BF16_W]),
      .ovf     (c2_ovf[gi]),
      .unf     (c2_unf[gi]),
      .inexact (c2_inx[gi])
    );
  end

  // Stage 1: capture sign, magnitude, leading-zero count and the vector's rounding mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_rm_reg    <= 1'b0;
      s1_sign_reg  <= '0;
      s1_mag_reg   <= '0;
      s1_lzc_reg   <= '0;
    end else if (in_ready) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_rm_reg   <= round_mode;
        s1_sign_reg <= c1_sign;
        s1_mag_reg  <= c1_mag;
        s1_lzc_reg  <= c1_lzc;
      end
    end
  end

  // Stage 2: capture packed BF16 words and per-lane exception bits; hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_bf16   <= '0;
      s2_ovf_reg <= '0;
      s2_unf_reg <= '0;
      s2_inx_reg <= '0;
    end else if (s2_en) begin
      out_valid <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_bf16   <= c2_bf16;
        s2_ovf_reg <= c2_ovf;
        s2_unf_reg <= c2_unf;
        s2_inx_reg <= c2_inx;
      end
    end
  end

  // Sticky flags accumulate on output transfer; a clear drops history but keeps a same-cycle event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_ovf     <= 1'b0;
      flag_unf     <= 1'b0;
      flag_inexact <= 1'b0;
    end else if (clr_flags) begin
      flag_ovf     <= xfer && (|s2_ovf_reg);
      flag_unf     <= xfer && (|s2_unf_reg);
      flag_inexact <= xfer && (|s2_inx_reg);
    end else begin
      flag_ovf     <= flag_ovf     || (xfer && (|s2_ovf_reg));
      flag_unf     <= flag_unf     || (xfer && (|s2_unf_reg));
      flag_inexact <= flag_inexact || (xfer && (|s2_inx_reg));
    end
  end

endmodule

// File: tb/tb_acc_to_bf16_pipe.sv
// Self-checking bench: vector table through a scoreboard, backpressure, sticky flags,
// mid-stream reset, an underflow-configured instance and a lane-level overflow table.
module tb_acc_to_bf16_pipe;
  import acc_bf16_pkg::*;

  localparam int ACC_W = 18;
  localparam int FRAC_BITS = 8;
  localparam int LANES = 4;

  typedef struct packed {
    logic [LANES*ACC_W-1:0] acc;
    logic                   rm;
    logic [LANES*16-1:0]    bf;
    logic                   inx;
  } vec_t;

  typedef struct packed {
    logic [17:0] acc;
    logic        rm;
    logic [15:0] bf;
    logic        ovf;
    logic        inx;
  } lvec_t;

  logic clk, rst_n;
  logic in_valid, in_ready, round_mode, out_valid, out_ready, clr_flags;
  logic [LANES*ACC_W-1:0] in_acc;
  logic [LANES*16-1:0]    out_bf16;
  logic flag_ovf, flag_unf, flag_inexact;

  logic u_in_valid, u_in_ready, u_rm, u_out_valid, u_out_ready, u_clr;
  logic [17:0] u_acc;
  logic [15:0] u_out;
  logic u_ovf, u_unf, u_inx;

  logic [17:0] l_acc, l_mag;
  logic l_sign, l_rm, l_ovf, l_unf, l_inx;
  logic [4:0] l_lzc;
  logic [15:0] l_bf;

  int checks = 0;
  int errors = 0;

  vec_t  tbl [8];
  lvec_t ltbl [6];
  vec_t  send_q [$];
  vec_t  sb_q [$];
  int    lat_q [$];
  int    cyc = 0;
  int    out_cnt = 0;
  logic  m_inx = 1'b0;
  logic  prev_stall = 1'b0;
  logic [LANES*16-1:0] prev_bf = '0;
  logic  lat_chk = 1'b0;
  logic  last_in_ready = 1'b0;

  acc_to_bf16_pipe #(.ACC_W(ACC_W), .FRAC_BITS(FRAC_BITS), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
    .round_mode(round_mode), .out_valid(out_valid), .out_ready(out_ready), .out_bf16(out_bf16),
    .clr_flags(clr_flags), .flag_ovf(flag_ovf), .flag_unf(flag_unf), .flag_inexact(flag_inexact)
  );

  acc_to_bf16_pipe #(.ACC_W(18), .FRAC_BITS(140), .LANES(1)) u_unf_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(u_in_valid), .in_ready(u_in_ready), .in_acc(u_acc),
    .round_mode(u_rm), .out_valid(u_out_valid), .out_ready(u_out_ready), .out_bf16(u_out),
    .clr_flags(u_clr), .flag_ovf(u_ovf), .flag_unf(u_unf), .flag_inexact(u_inx)
  );

  acc_bf16_lane #(.ACC_W(18), .FRAC_BITS(0), .EXP_BIAS(240)) u_lane (
    .acc(l_acc), .s1_sign(l_sign), .s1_mag(l_mag), .s1_lzc(l_lzc),
    .s2_sign(l_sign), .s2_mag(l_mag), .s2_lzc(l_lzc), .s2_rm(l_rm),
    .bf16(l_bf), .ovf(l_ovf), .unf(l_unf), .inexact(l_inx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // One clock cycle of the main DUT: check flags/stall stability, drive, score handshakes.
  task automatic step(input logic ordy, input logic clr);
    logic fire_in, fire_out, ev;
    vec_t e;
    int   c0;
    @(negedge clk);
    cyc++;
    chk("flag_inexact", {63'b0, flag_inexact}, {63'b0, m_inx});
    chk("flag_ovf", {63'b0, flag_ovf}, 64'd0);
    chk("flag_unf", {63'b0, flag_unf}, 64'd0);
    if (prev_stall) begin
      chk("stall_valid", {63'b0, out_valid}, 64'd1);
      chk("stall_data", out_bf16, prev_bf);
    end
    out_ready = ordy;
    clr_flags = clr;
    if (send_q.size() > 0) begin
      in_valid = 1'b1;
      in_acc = send_q[0].acc;
      round_mode = send_q[0].rm;
    end else begin
      in_valid = 1'b0;
      in_acc = {3{24'hA5A5A5}};
      round_mode = 1'b0;
    end
    #1;
    last_in_ready = in_ready;
    fire_in = in_valid & in_ready;
    fire_out = out_valid & out_ready;
    ev = 1'b0;
    if (fire_out) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %h required no output", out_bf16);
      end else begin
        e = sb_q.pop_front();
        c0 = lat_q.pop_front();
        out_cnt++;
        $display("out %0d: bf16 %h expected %h", out_cnt, out_bf16, e.bf);
        chk("out_bf16", out_bf16, e.bf);
        if (lat_chk) chk("latency", 64'(cyc - c0), 64'd2);
        ev = e.inx;
      end
    end
    if (fire_in) begin
      sb_q.push_back(send_q.pop_front());
      lat_q.push_back(cyc);
    end
    m_inx = clr ? (fire_out & ev) : (m_inx | (fire_out & ev));
    prev_stall = out_valid & ~out_ready;
    prev_bf = out_bf16;
  endtask

  initial begin
    // Lanes listed {lane3, lane2, lane1, lane0}.
    tbl[0] = '{acc: {18'h20000, 18'h00000, 18'h3FF00, 18'h00100}, rm: 1'b0,
               bf: {16'hC400, 16'h0000, 16'hBF80, 16'h3F80}, inx: 1'b0};
    tbl[1] = '{acc: {18'h00000, 18'h00100, 18'h00103, 18'h00101}, rm: 1'b0,
               bf: {16'h0000, 16'h3F80, 16'h3F82, 16'h3F80}, inx: 1'b1};
    tbl[2] = '{acc: {18'h3FFFF, 18'h00080, 18'h00000, 18'h1FFFF}, rm: 1'b0,
               bf: {16'hBB80, 16'h3F00, 16'h0000, 16'h4400}, inx: 1'b1};
    tbl[3] = '{acc: {18'h3FF00, 18'h00101, 18'h00103, 18'h1FFFF}, rm: 1'b1,
               bf: {16'hBF80, 16'h3F80, 16'h3F81, 16'h43FF}, inx: 1'b1};
    tbl[4] = '{acc: {18'h00000, 18'h00000, 18'h00000, 18'h00000}, rm: 1'b0,
               bf: {16'h0000, 16'h0000, 16'h0000, 16'h0000}, inx: 1'b0};
    tbl[5] = '{acc: {18'h000FF, 18'h00003, 18'h00002, 18'h00001}, rm: 1'b0,
               bf: {16'h3F7F, 16'h3C40, 16'h3C00, 16'h3B80}, inx: 1'b0};
    tbl[6] = '{acc: {18'h00180, 18'h00182, 18'h00183, 18'h00181}, rm: 1'b0,
               bf: {16'h3FC0, 16'h3FC1, 16'h3FC2, 16'h3FC0}, inx: 1'b1};
    tbl[7] = '{acc: {18'h20000, 18'h00000, 18'h00100, 18'h3FEFF}, rm: 1'b1,
               bf: {16'hC400, 16'h0000, 16'h3F80, 16'hBF80}, inx: 1'b1};

    // Lane with exponent bias 240, FRAC_BITS 0: E = p + 240.
    ltbl[0] = '{acc: 18'h04000, rm: 1'b0, bf: 16'h7F00, ovf: 1'b0, inx: 1'b0};
    ltbl[1] = '{acc: 18'h07FFF, rm: 1'b0, bf: 16'h7F80, ovf: 1'b1, inx: 1'b1};
    ltbl[2] = '{acc: 18'h07FFF, rm: 1'b1, bf: 16'h7F7F, ovf: 1'b0, inx: 1'b1};
    ltbl[3] = '{acc: 18'h08000, rm: 1'b0, bf: 16'h7F80, ovf: 1'b1, inx: 1'b1};
    ltbl[4] = '{acc: 18'h38000, rm: 1'b0, bf: 16'hFF80, ovf: 1'b1, inx: 1'b1};
    ltbl[5] = '{acc: 18'h00000, rm: 1'b0, bf: 16'h0000, ovf: 1'b0, inx: 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_acc = '0; round_mode = 1'b0; out_ready = 1'b1; clr_flags = 1'b0;
    u_in_valid = 1'b0; u_acc = '0; u_rm = 1'b0; u_out_ready = 1'b1; u_clr = 1'b0;
    l_acc = '0; l_rm = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state.
    @(negedge clk); #1;
    chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_bf16", out_bf16, 64'd0);
    chk("rst_flags", {61'b0, flag_ovf, flag_unf, flag_inexact}, 64'd0);

    // Full-throughput stream with latency checks.
    lat_chk = 1'b1;
    for (int i = 0; i < 8; i++) send_q.push_back(tbl[i]);
    for (int k = 0; k < 12; k++) step(1'b1, 1'b0);
    lat_chk = 1'b0;
    chk("stream_count", 64'(out_cnt), 64'd8);

    // Backpressure: out_ready low during stream cycles 3..6.
    out_cnt = 0;
    for (int i = 0; i < 8; i++) send_q.push_back(tbl[i]);
    for (int k = 0; k < 16; k++) begin
      step(!(k >= 3 && k <= 6), 1'b0);
      if (k >= 3 && k <= 6) chk("bp_in_ready", {63'b0, last_in_ready}, 64'd0);
    end
    chk("bp_count", 64'(out_cnt), 64'd8);
    chk("bp_left", 64'(sb_q.size() + send_q.size()), 64'd0);

    // clr_flags held while an exact then an inexact vector transfer, then a lone clear.
    send_q.push_back(tbl[0]);
    send_q.push_back(tbl[1]);
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Reset with both stages full.
    send_q.push_back(tbl[1]);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
    send_q.push_back(tbl[2]);
    send_q.push_back(tbl[6]);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0);
    chk("full_in_ready", {63'b0, last_in_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("mid_rst_out_bf16", out_bf16, 64'd0);
    chk("mid_rst_flags", {61'b0, flag_ovf, flag_unf, flag_inexact}, 64'd0);
    sb_q.delete(); send_q.delete(); lat_q.delete();
    m_inx = 1'b0; prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0);
    out_cnt = 0;
    send_q.push_back(tbl[5]);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
    chk("post_rst_count", 64'(out_cnt), 64'd1);

    // FRAC_BITS=140 instance: -1 underflows to signed zero, -2^17 stays normal.
    @(negedge clk);
    u_in_valid = 1'b1; u_acc = 18'h3FFFF; u_out_ready = 1'b1;
    #1 chk("unf_in_ready", {63'b0, u_in_ready}, 64'd1);
    @(negedge clk);
    u_acc = 18'h20000;
    @(negedge clk);
    u_in_valid = 1'b0;
    #1;
    chk("unf_valid0", {63'b0, u_out_valid}, 64'd1);
    chk("unf_out0", {48'b0, u_out}, 64'h8000);
    @(negedge clk); #1;
    chk("unf_valid1", {63'b0, u_out_valid}, 64'd1);
    chk("unf_out1", {48'b0, u_out}, 64'h8200);
    chk("unf_flag_early", {63'b0, u_unf}, 64'd1);
    @(negedge clk); #1;
    chk("unf_idle", {63'b0, u_out_valid}, 64'd0);
    chk("unf_flags", {61'b0, u_ovf, u_unf, u_inx}, 64'd3);
    u_clr = 1'b1;
    @(negedge clk);
    u_clr = 1'b0;
    #1 chk("unf_cleared", {61'b0, u_ovf, u_unf, u_inx}, 64'd0);

    // Lane-level overflow table (raised exponent bias).
    for (int i = 0; i < 6; i++) begin
      l_acc = ltbl[i].acc;
      l_rm = ltbl[i].rm;
      #1;
      $display("lane %0d: acc %h bf16 %h expected %h", i, l_acc, l_bf, ltbl[i].bf);
      chk("lane_bf16", {48'b0, l_bf}, {48'b0, ltbl[i].bf});
      chk("lane_flags", {61'b0, l_ovf, l_unf, l_inx}, {61'b0, ltbl[i].ovf, 1'b0, ltbl[i].inx});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_to_bf16_pipe.md
Name: acc_to_bf16_pipe

Overview:
- Multi-lane, pipelined converter from signed fixed-point accumulator words (Q(ACC_W-FRAC_BITS).FRAC_BITS) to BF16.
- Sits between the systolic array accumulator drain and the BF16 output/writeback path.
- Parametrised in accumulator width, fractional bits and lane count; adds runtime rounding mode, valid/ready backpressure, mantissa-carry handling and sticky exception flags.

Parameters:
- ACC_W, 18, accumulator width in bits (two's complement); legal range 4..32.
- FRAC_BITS, 8, fractional bits of input; legal range 0..160.
- LANES, 4, independent conversion lanes sharing one handshake.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  converter can accept the input vector.
- in_acc  in  LANES*ACC_W  lane i at bits [i*ACC_W +: ACC_W], signed.
- round_mode  in  1  0 = round-nearest-even, 1 = truncate toward zero; sampled with in_valid & in_ready.
- out_valid  out  1  output vector valid.
- out_ready  in  1  downstream accepts.
- out_bf16  out  LANES*16  lane i at bits [i*16 +: 16].
- clr_flags  in  1  synchronous clear of the sticky flags.
- flag_ovf  out  1  sticky: some lane produced ±inf.
- flag_unf  out  1  sticky: some lane flushed a nonzero value to zero.
- flag_inexact  out  1  sticky: some lane discarded nonzero bits.

Behaviour:
- Reset (async, rst_n=0): both stage valids 0, out_valid=0, out_bf16=0, all flags 0. in_ready=1 from the first cycle after reset.
- Two-stage pipeline with fixed latency of 2 accepted-to-valid cycles.
  - S1 registers sign, magnitude and leading-zero count per lane.
  - S2 registers the packed BF16 and per-lane exception bits.
- Handshake:
  - Stage k advances when its successor is empty or advancing; in_ready = !s1_valid | s1_advance.
  - out_valid/out_bf16 hold stable while out_valid & !out_ready.
  - Full throughput is 1 vector/cycle.
  - A full pipe under a stall holds 2 vectors; nothing is dropped or duplicated.
- Magnitude: |acc| is computed in ACC_W bits unsigned. The most negative input (-2^(ACC_W-1)) is exact (magnitude 2^(ACC_W-1)).
- Zero input: output 0x0000 (positive zero), no flags.
- Exponent: p = index of MSB of magnitude; E = p - FRAC_BITS + 127, computed in a signed width that holds every value of the parameter range.
- Mantissa:
  - The 7 bits below the MSB form the mantissa; bits shifted below are zero-extended when p < 7.
  - G = next bit; S = OR of all lower bits.
- RNE: increment when G & (S | mant[0]). Truncate: never increment.
- Mantissa carry-out (0x7F + 1): mantissa becomes 0 and E increments.
- inexact_lane = G | S, set before rounding in both modes.
- Post-round E >= 255: output {sign, 0xFF, 0x00} (±inf); ovf_lane=1; inexact_lane=1.
- E <= 0: output {sign, 15'b0} (signed zero, no subnormals); unf_lane=1; inexact_lane=1.
- Sticky flags: set on the cycle an S2 vector is transferred (out_valid & out_ready) with the OR of the lane bits. If clr_flags coincides with that transfer, clr wins for previous state and the new event still sets (flag = new_event).
- round_mode travels with its vector; a mode change mid-stream affects only vectors accepted after it.
- Reset mid-operation discards in-flight vectors; no partial output appears.

Decomposition:
- Shared package acc_bf16_pkg: BF16_BIAS=127, BF16_EXP_MAX=255, BF16 field widths, RM_RNE/RM_TRUNC encodings, BF16_POS_INF/BF16_NEG_INF constants.
- Sub-module acc_bf16_lane, instantiated LANES times:
  - combinational S1 logic (abs, leading-zero detect);
  - combinational S2 logic (shift, round, pack, exception bits).
- The top owns pipeline registers, handshake and sticky flags.

Test Plan:
- Defaults, RNE, one lane each:
  - 0x00100 -> 0x3F80.
  - 0x3FF00 (-1.0) -> 0xBF80.
  - 0x00000 -> 0x0000.
  - 0x20000 (-512) -> 0xC400.
- RNE ties:
  - 0x00101 -> 0x3F80 (tie to even), inexact=1.
  - 0x00103 -> 0x3F82.
- Mantissa carry:
  - 0x1FFFF with RNE -> 0x4400.
  - Same input with truncate -> 0x43FF.
  - Both set flag_inexact.
- Backpressure:
  - Stream 8 vectors back-to-back; hold out_ready=0 for cycles 3-6.
  - Required: in_ready drops within 1 cycle, outputs stable while stalled, all 8 vectors emerge in order; first output valid 2 cycles after acceptance.
- Exceptions:
  - FRAC_BITS=140, acc=1 -> 0x0000, flag_unf=1.
  - ACC_W=32, FRAC_BITS=0, with BF16_BIAS overridden to a smaller test value in a bench copy of the package -> inf path; alternatively, a directed lane-level test with forced E=255 -> 0x7F80, flag_ovf=1.
  - clr_flags clears all flags next cycle.
- Reset mid-stream:
  - Assert rst_n=0 with both stages full.
  - Required: out_valid=0 immediately, flags 0, no stale vector after release.
